// File: rtl/jt51_cpu_fifo_if.sv
// jt51_cpu_fifo_if: host-side write bus plus MMR drain handshake for jt51_cpu_fifo.
// Host side: cs_n/wr_n/a0/d_in strobes in; busy/level/overflow status out; clr_ovf in.
// MMR side: cen tick and mmr_busy in; mmr_write/mmr_a0/mmr_din request out.
interface jt51_cpu_fifo_if #(
  parameter int AW = 3
);
  logic          cen;
  logic          cs_n;
  logic          wr_n;
  logic          a0;
  logic [7:0]    d_in;
  logic          busy;
  logic [AW:0]   level;
  logic          overflow;
  logic          clr_ovf;
  logic          mmr_write;
  logic          mmr_a0;
  logic [7:0]    mmr_din;
  logic          mmr_busy;

  // The FIFO itself: consumes strobes and cen, produces status and MMR requests.
  modport slave (
    input  cen, cs_n, wr_n, a0, d_in, clr_ovf, mmr_busy,
    output busy, level, overflow, mmr_write, mmr_a0, mmr_din
  );

  // The environment: host plus MMR model.
  modport master (
    output cen, cs_n, wr_n, a0, d_in, clr_ovf, mmr_busy,
    input  busy, level, overflow, mmr_write, mmr_a0, mmr_din
  );
endinterface

// File: rtl/jt51_cpu_fifo.sv
// jt51_cpu_fifo: queues host {a0,data} writes and drains them to the MMR one per
// handshake, with GAP idle cen ticks after each completed write.
// Ports: clk, rst (async, active-high), bus (jt51_cpu_fifo_if.slave).
module jt51_cpu_fifo #(
  parameter int AW     = 3,
  parameter int GAP    = 2,
  parameter int COMPAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  jt51_cpu_fifo_if.slave    bus
);

  localparam int DEPTH = 1 << AW;
  localparam int GW    = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [AW:0]   FULL  = {1'b1, {AW{1'b0}}};
  localparam logic [GW-1:0] GAP_N = GW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t        state;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic [8:0]    mem [DEPTH];
  logic          wr, wr_l;
  logic          push_edge, push, pop, full;
  logic          ovf;
  logic          mmr_write_r, mmr_a0_r;
  logic [7:0]    mmr_din_r;
  logic [GW-1:0] gap_cnt;

  assign wr        = ~bus.cs_n & ~bus.wr_n;
  assign push_edge = wr & ~wr_l;
  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == FULL);
  // The head leaves on the ISSUE->WAIT tick; that frees a slot for a
  // same-cycle push even when the FIFO is full.
  assign pop       = bus.cen & (state == S_ISSUE);
  assign push      = push_edge & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_l   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_l <= wr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A drop wins over a clear arriving in the same cycle.
      if (push_edge & full & ~pop) ovf <= 1'b1;
      else if (bus.clr_ovf)        ovf <= 1'b0;
    end
  end

  // Storage needs no reset: only entries counted by level are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.a0, bus.d_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mmr_write_r <= 1'b0;
      mmr_a0_r    <= 1'b0;
      mmr_din_r   <= 8'h00;
      gap_cnt     <= '0;
    end else if (bus.cen) begin
      case (state)
        S_IDLE: begin
          if (level != '0) begin
            {mmr_a0_r, mmr_din_r} <= mem[rd_ptr[AW-1:0]];
            mmr_write_r           <= 1'b1;
            state                 <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mmr_write_r <= 1'b0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.mmr_busy) begin
            if (GAP > 0) begin
              gap_cnt <= GAP_N;
              state   <= S_GAP;
            end else begin
              state   <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          // gap_cnt holds the ticks left including this one.
          if (gap_cnt <= GW'(1)) state <= S_IDLE;
          else                   gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (COMPAT != 0) ? ((level != '0) | (state != S_IDLE)) : full;
  assign bus.level     = level;
  assign bus.overflow  = ovf;
  assign bus.mmr_write = mmr_write_r;
  assign bus.mmr_a0    = mmr_a0_r;
  assign bus.mmr_din   = mmr_din_r;

endmodule

// File: tb/tb_jt51_cpu_fifo.sv
// tb_jt51_cpu_fifo: scoreboard bench for jt51_cpu_fifo; two instances (COMPAT=0/1)
// share one stimulus stream, issued entries of instance 0 are popped and compared.
// Ports: none (top level).
module tb_jt51_cpu_fifo;
  localparam int AW  = 3;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1, wr_n = 1'b1, a0 = 1'b0, clr_ovf = 1'b0, mmr_busy = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       cdiv = 1'b0, cen_man = 1'b0, cen_w;
  int         cen_mode = 0;   // 0: cen_man, 1: every 2nd clk, 2: held high

  int         n_vec = 0, n_miss = 0;
  int         ticks = 0, last_tick = -1;
  bit         spc_on = 1'b0;
  logic [8:0] sb[$];

  jt51_cpu_fifo_if #(.AW(AW)) bus0 ();
  jt51_cpu_fifo_if #(.AW(AW)) bus1 ();

  jt51_cpu_fifo #(.AW(AW), .GAP(GAP), .COMPAT(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  jt51_cpu_fifo #(.AW(AW), .GAP(GAP), .COMPAT(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cdiv <= ~cdiv;
  always @(posedge clk) if (cen_w) ticks <= ticks + 1;

  assign cen_w = (cen_mode == 1) ? cdiv : (cen_mode == 2) ? 1'b1 : cen_man;

  assign bus0.cen = cen_w;      assign bus1.cen = cen_w;
  assign bus0.cs_n = cs_n;      assign bus1.cs_n = cs_n;
  assign bus0.wr_n = wr_n;      assign bus1.wr_n = wr_n;
  assign bus0.a0 = a0;          assign bus1.a0 = a0;
  assign bus0.d_in = d_in;      assign bus1.d_in = d_in;
  assign bus0.clr_ovf = clr_ovf;   assign bus1.clr_ovf = clr_ovf;
  assign bus0.mmr_busy = mmr_busy; assign bus1.mmr_busy = mmr_busy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic host_wr(input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; d_in = d;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Issue monitor: one pop per cen tick with mmr_write high.
  always @(negedge clk) begin
    logic [8:0] got, exp;
    if (!rst && cen_w && bus0.mmr_write) begin
      got = {bus0.mmr_a0, bus0.mmr_din};
      if (sb.size() == 0) begin
        chk("spurious_issue", 32'(got) | 32'h1000, 0);
      end else begin
        exp = sb.pop_front();
        chk("issue", 32'(got), 32'(exp));
      end
      if (spc_on) begin
        if (last_tick >= 0) chk("spacing", 32'(ticks - last_tick >= 2 + GAP), 1);
        last_tick = ticks;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_busy_c1", 32'(bus1.busy), 0);
    chk("rst_level", 32'(bus0.level), 0);
    chk("rst_ovf", 32'(bus0.overflow), 0);
    chk("rst_write", 32'(bus0.mmr_write), 0);
    chk("rst_mmr", 32'({bus0.mmr_a0, bus0.mmr_din}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single write pair, cen every 2 clk, spacing check
    cen_mode = 1; spc_on = 1'b1;
    sb.push_back({1'b0, 8'h14}); host_wr(1'b0, 8'h14);
    sb.push_back({1'b1, 8'h15}); host_wr(1'b1, 8'h15);
    wait_drain(200);
    spc_on = 1'b0;
    chk("single_level", 32'(bus0.level), 0);
    chk("single_busy_c1", 32'(bus1.busy), 0);
    chk("hold_mmr", 32'({bus0.mmr_a0, bus0.mmr_din}), 32'h115);

    // Burst to full with cen stopped, 9th write dropped
    cen_mode = 0; cen_man = 1'b0; mmr_busy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back({1'b0, 8'(i)});
      host_wr(1'b0, 8'(i));
    end
    @(negedge clk);
    chk("burst_level", 32'(bus0.level), 8);
    chk("burst_busy", 32'(bus0.busy), 1);
    chk("burst_ovf", 32'(bus0.overflow), 1);
    cen_mode = 2;
    repeat (10) @(negedge clk);
    chk("stuck_level", 32'(bus0.level), 7);
    chk("stuck_busy", 32'(bus0.busy), 0);
    chk("stuck_sb", 32'(sb.size()), 7);
    @(posedge clk); #1 mmr_busy = 1'b0; cen_mode = 1;
    wait_drain(400);
    chk("ovf_sticky", 32'(bus0.overflow), 1);
    clr_ovf = 1'b1; @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 32'(bus0.overflow), 0);

    // Long strobe counts once
    cen_mode = 0; cen_man = 1'b0;
    @(posedge clk); #1 cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d_in = 8'h5A;
    repeat (20) @(posedge clk);
    #1 cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    chk("long_level", 32'(bus0.level), 1);
    sb.push_back({1'b1, 8'h5A});
    cen_mode = 1;
    wait_drain(200);

    // Full FIFO, push lands on the pop tick
    cen_mode = 0; cen_man = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back({1'b0, 8'(8'h20 + i)});
      host_wr(1'b0, 8'(8'h20 + i));
    end
    @(negedge clk);
    chk("fp_level_full", 32'(bus0.level), 8);
    @(posedge clk); #1 cen_man = 1'b1;
    @(posedge clk); #1 cen_man = 1'b1; cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; d_in = 8'h28;
    sb.push_back({1'b0, 8'h28});
    @(posedge clk); #1 cen_man = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    chk("fp_level", 32'(bus0.level), 8);
    chk("fp_ovf", 32'(bus0.overflow), 0);
    cen_mode = 1;
    wait_drain(400);

    // COMPAT busy tracks pending work through WAIT and GAP
    cen_mode = 2; mmr_busy = 1'b1;
    sb.push_back({1'b0, 8'h33});
    @(posedge clk); #1 cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b0; d_in = 8'h33;
    @(posedge clk); #1 cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    chk("c1_busy_push", 32'(bus1.busy), 1);
    chk("c0_busy_push", 32'(bus0.busy), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("c1_busy_wait", 32'(bus1.busy), 1);
    end
    @(posedge clk); #1 mmr_busy = 1'b0;
    @(negedge clk); chk("c1_busy_rel", 32'(bus1.busy), 1);
    @(negedge clk); chk("c1_busy_gap1", 32'(bus1.busy), 1);
    @(negedge clk); chk("c1_busy_gap2", 32'(bus1.busy), 1);
    @(negedge clk); chk("c1_busy_idle", 32'(bus1.busy), 0);
    chk("c1_sb", 32'(sb.size()), 0);
    repeat (10) @(posedge clk);

    // Reset while the first of three entries is in WAIT
    cen_mode = 0; cen_man = 1'b0; mmr_busy = 1'b1;
    sb.push_back({1'b0, 8'h41});
    host_wr(1'b0, 8'h41); host_wr(1'b0, 8'h42); host_wr(1'b0, 8'h43);
    cen_mode = 2;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_write", 32'(bus0.mmr_write), 0);
    chk("rst_mid_level", 32'(bus0.level), 0);
    chk("rst_mid_busy", 32'(bus0.busy), 0);
    chk("rst_mid_busy_c1", 32'(bus1.busy), 0);
    chk("rst_mid_sb", 32'(sb.size()), 0);
    @(posedge clk); #1 rst = 1'b0; mmr_busy = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("post_rst_level", 32'(bus0.level), 0);
    chk("final_sb", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/jt51_cpu_fifo.md
# jt51_cpu_fifo

Buffered CPU write port for the JT51 core. It captures host register writes on the system clock, queues them as {a0, data} entries in a parametrised FIFO, and drains them into the register bank (MMR) one at a time. Each drain obeys a busy handshake and a programmable minimum spacing counted in MMR clock-enable ticks. It replaces the single-entry write latch and derived-clock synchroniser with a single-clock, clock-enable design that lets a host burst writes without polling the busy bit.

## Interface

Parameters:
- AW, 3: FIFO address width; depth = 2**AW entries; AW ≥ 1.
- GAP, 2: idle cen ticks inserted after each completed MMR write; 0 allowed.
- COMPAT, 0: 1 = YM2151-style busy (high whenever anything is pending); 0 = busy only when the FIFO is full.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset rst, asynchronous, active-high; clock clk.
- cen  in  1  MMR clock enable (one clk pulse per MMR cycle); all drain-side logic advances only when cen=1.
- cs_n  in  1  chip select, active-low.
- wr_n  in  1  write strobe, active-low.
- a0  in  1  0 = address write, 1 = data write.
- d_in  in  8  host data.
- busy  out  1  host busy flag.
- level  out  AW+1  entries currently queued, 0..2**AW.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow on clk.
- mmr_write  out  1  write request to MMR, valid on cen.
- mmr_a0  out  1  a0 of the entry being issued.
- mmr_din  out  8  data of the entry being issued.
- mmr_busy  in  1  MMR busy, sampled only when cen=1.

## Operation

- Push: one push per rising edge of wr = !cs_n & !wr_n, detected by a registered copy of wr. A strobe held low for many cycles counts once.
  - Entry = {a0, d_in} sampled on the edge cycle.
  - If level == 2**AW, the entry is dropped and overflow is set.
- Pointers: rd/wr pointers are AW+1 bits with natural wrap. level = wr_ptr − rd_ptr.
- Drain FSM (advances on cen only):
  - IDLE: if level ≠ 0, load the head entry into mmr_a0/mmr_din, set mmr_write=1, go to ISSUE.
  - ISSUE: mmr_write=1 for exactly this one cen tick. Next cen: mmr_write=0, pop the head, go to WAIT.
  - WAIT: stay while the sampled mmr_busy = 1. On the first cen with mmr_busy = 0, go to GAP if GAP > 0, else IDLE.
  - GAP: count GAP cen ticks, then go to IDLE.
- Entries are popped on the ISSUE→WAIT transition. From then on level excludes the entry in flight.
- Simultaneous push and pop in one clk cycle: both occur; level unchanged. A push into a full FIFO during the pop cycle is accepted (the pop frees the space first).
- busy:
  - COMPAT=0: busy = (level == 2**AW).
  - COMPAT=1: busy = (level ≠ 0) | (state ≠ IDLE).
- overflow: set has priority over clr_ovf in the same cycle.
- mmr_a0/mmr_din hold their last issued value while idle.

## Timing

- Reset values: busy=0, level=0, overflow=0, mmr_write=0, mmr_a0=0, mmr_din=0, state=IDLE, pointers=0.
- Reset mid-drain discards all entries and deasserts mmr_write immediately (asynchronous).
- Push latency: strobe edge seen in clk cycle n; level and busy update in cycle n+1.
- Issue latency: entry queued in cycle n+1 into an IDLE FSM; mmr_write rises on the first cen at or after n+1.
- Minimum spacing between mmr_write pulses: 2 + GAP cen ticks (ISSUE, ≥1 WAIT, GAP).
- With cen held at 1, the path behaves as a fully clk-rate pipeline.
- mmr_busy is ignored outside WAIT and on clk cycles where cen = 0.

## Test plan

- Single write: cen every 2 clk, GAP=2, mmr_busy=0; host writes a0=0, d=0x14.
  - Expect: one mmr_write pulse of one cen tick, mmr_a0=0, mmr_din=0x14; level returns to 0; next issue allowed no sooner than 4 cen ticks later.
- Burst to full: AW=3, mmr_busy held 1, 9 back-to-back strobes with d=0x01..0x09.
  - Expect: 0x01 issued; level reaches 8; busy=1; overflow=1; 0x09 never appears.
  - Then release mmr_busy: 0x02..0x08 are issued in order. Pulse clr_ovf → overflow=0.
- Long strobe: wr_n held low 20 clk cycles → exactly one entry pushed, level=1.
- Full plus simultaneous pop: FIFO full, push lands on the ISSUE→WAIT pop cycle → push accepted, level stays 8, overflow stays 0.
- COMPAT=1: one write with mmr_busy high for 5 cen ticks → busy stays 1 from the push cycle until the FSM returns to IDLE after GAP, then drops to 0.
- Reset mid-drain: 3 entries queued, rst asserted while in WAIT → mmr_write=0, level=0, busy=0 immediately. After release, no stale entry is issued.
